// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: op codes, flag bit
// positions and the control FSM state encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_MULU = 4'd3,
    OP_DIV  = 4'd4,
    OP_MOD  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_EOR  = 4'd8,
    OP_NOT  = 4'd9,
    OP_LSL  = 4'd10,
    OP_LSR  = 4'd11,
    OP_ASR  = 4'd12,
    OP_ROR  = 4'd13,
    OP_RSVD = 4'd14,
    OP_CMP  = 4'd15
  } alu_op_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } alu_state_e;

  function automatic logic is_iter_op(alu_op_e op);
    return op inside {OP_MUL, OP_MULU, OP_DIV, OP_MOD};
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier and restoring divider sharing one
// 2*WIDTH accumulator; one bit per step, outputs reflect the post-step value.
module alu_iter_muldiv #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               mode,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] shl;

  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    shl   = acc_q << 1;
    trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
    if (load) begin
      acc_d = {{WIDTH{1'b0}}, a};
      b_d   = b;
    end else if (step) begin
      if (!mode) begin
        acc_d = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
      end else begin
        // Partial remainder stays below the divisor, so trial[WIDTH] is a clean borrow.
        acc_d = trial[WIDTH] ? shl : {trial[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
    end
  end

  always_comb begin
    product   = acc_d;
    quotient  = acc_d[WIDTH-1:0];
    remainder = acc_d[2*WIDTH-1:WIDTH];
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops complete immediately, MUL/MULU/DIV/MOD
// run on the iterative datapath behind a start/busy/done handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_nzcv,
  output logic             div_zero
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  alu_op_e          op_q, op_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             dz_q, dz_d;

  alu_op_e            op_in;
  logic               load, step, mode, cap_sc, cap_it, div0;
  logic [WIDTH:0]     add_full, sub_full, cmp_full;
  logic [SHW-1:0]     sh, sh_neg;
  logic               sh_big;
  logic [WIDTH-1:0]   sc_res, it_res;
  logic [3:0]         sc_flags, it_flags;
  logic               sc_c, sc_v, sc_dz, it_v;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient, remainder;

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .mode      (mode),
    .step      (step),
    .a         (a_in),
    .b         (b_in),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Single-cycle ops evaluate straight from the inputs on the accepting edge.
  always_comb begin
    op_in    = alu_op_e'(op);
    add_full = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, carry_in};
    sub_full = {1'b0, a_in} - {1'b0, b_in} - {{WIDTH{1'b0}}, carry_in};
    cmp_full = {1'b0, a_in} - {1'b0, b_in};
    sh       = b_in[SHW-1:0];
    sh_neg   = ~sh + 1'b1;
    sh_big   = |b_in[WIDTH-1:SHW];
    sc_res   = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_dz    = 1'b0;
    case (op_in)
      OP_ADD: begin
        sc_res = add_full[WIDTH-1:0];
        sc_c   = add_full[WIDTH];
        sc_v   = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (add_full[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_full[WIDTH-1:0];
        sc_c   = sub_full[WIDTH];
        sc_v   = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (sub_full[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_DIV: begin
        sc_res = '1;
        sc_v   = 1'b1;
        sc_dz  = 1'b1;
      end
      OP_MOD: begin
        sc_res = a_in;
        sc_v   = 1'b1;
        sc_dz  = 1'b1;
      end
      OP_AND:  sc_res = a_in & b_in;
      OP_OR:   sc_res = a_in | b_in;
      OP_EOR:  sc_res = a_in ^ b_in;
      OP_NOT:  sc_res = ~a_in;
      OP_LSL:  sc_res = sh_big ? '0 : a_in << sh;
      OP_LSR:  sc_res = sh_big ? '0 : a_in >> sh;
      OP_ASR:  sc_res = sh_big ? {WIDTH{a_in[WIDTH-1]}} : $signed(a_in) >>> sh;
      // Left shift by (-sh mod WIDTH) is zero-width when sh = 0, so no special case.
      OP_ROR:  sc_res = (a_in >> sh) | (a_in << sh_neg);
      default: ;
    endcase
    sc_flags = '0;
    if (op_in == OP_CMP) begin
      sc_flags[FLAG_N] = cmp_full[WIDTH-1];
      sc_flags[FLAG_Z] = (cmp_full[WIDTH-1:0] == '0);
      sc_flags[FLAG_C] = cmp_full[WIDTH];
      sc_flags[FLAG_V] = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (cmp_full[WIDTH-1] != a_in[WIDTH-1]);
    end else if (op_in != OP_RSVD) begin
      sc_flags[FLAG_N] = sc_res[WIDTH-1];
      sc_flags[FLAG_Z] = (sc_res == '0);
      sc_flags[FLAG_C] = sc_c;
      sc_flags[FLAG_V] = sc_v;
    end
  end

  always_comb begin
    mode   = (op_q == OP_DIV) || (op_q == OP_MOD);
    it_res = '0;
    it_v   = 1'b0;
    case (op_q)
      OP_MUL: begin
        it_res = product[WIDTH-1:0];
        it_v   = |product[2*WIDTH-1:WIDTH];
      end
      OP_MULU: it_res = product[2*WIDTH-1:WIDTH];
      OP_DIV:  it_res = quotient;
      OP_MOD:  it_res = remainder;
      default: ;
    endcase
    it_flags         = '0;
    it_flags[FLAG_N] = it_res[WIDTH-1];
    it_flags[FLAG_Z] = (it_res == '0);
    it_flags[FLAG_V] = it_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      dz_q     <= dz_d;
    end
  end

  // Results are captured on the edge entering DONE so they are valid with the pulse.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    cap_sc  = 1'b0;
    cap_it  = 1'b0;
    div0    = (op_in inside {OP_DIV, OP_MOD}) && (b_in == '0);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d = op_in;
          if (is_iter_op(op_in) && !div0) begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = CALC;
          end else begin
            cap_sc  = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          cap_it  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    dz_d     = dz_q;
    if (cap_sc) begin
      result_d = sc_res;
      flags_d  = sc_flags;
      dz_d     = sc_dz;
    end else if (cap_it) begin
      result_d = it_res;
      flags_d  = it_flags;
      dz_d     = 1'b0;
    end
  end

  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    result     = result_q;
    flags_nzcv = flags_q;
    div_zero   = dz_q;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the processor's single-cycle ALU. Simple operations finish in one clock; multiply, divide and modulo run on a shared iterative datapath. A start/busy/done handshake lets the control unit stall on long operations. Adds rotate-right, a true compare, a divide-by-zero indication and registered results and flags.

## Interface
- WIDTH, 16: operand/result width, ≥ 4, power of two
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when busy = 0
- op  in  4  operation code, alu_op_e
- a_in  in  WIDTH  operand A
- b_in  in  WIDTH  operand B
- carry_in  in  1  carry/borrow input for ADD/SUB
- busy  out  1  operation in flight; start ignored
- done  out  1  one-cycle pulse; result and flags valid
- result  out  WIDTH  registered result, held until next done
- flags_nzcv  out  4  registered {N,Z,C,V}, held until next done
- div_zero  out  1  registered; set on DIV/MOD with b_in = 0

## Operation
- Operands, op and carry_in are latched on the accepted start. Later input changes have no effect.
- Op codes:
  - 0 ADD: A+B+cin; C = carry out; V = A,B same sign and result sign differs.
  - 1 SUB: A−B−cin; C = borrow; V = A,B signs differ and result sign ≠ A sign.
  - 2 MUL: low WIDTH bits of the unsigned product; V = upper half ≠ 0; C = 0.
  - 3 MULU: upper WIDTH bits of the unsigned product; C = V = 0.
  - 4 DIV, 5 MOD: unsigned quotient and remainder.
  - 6 AND, 7 OR, 8 EOR.
  - 9 NOT: ~A.
  - 10 LSL, 11 LSR, 12 ASR: amount is B. If B ≥ WIDTH the result is 0 for LSL/LSR and sign-fill for ASR.
  - 13 ROR: amount is B mod WIDTH.
  - 15 CMP: result = 0; N, Z, C, V computed exactly as for SUB with cin = 0.
  - 14 is reserved: result 0, flags 0000.
- N = result MSB and Z = (result == 0) for every op except CMP and reserved.
- C and V are 0 for ops that do not define them.
- DIV/MOD with B = 0: no iteration. DIV result is all ones; MOD result is A; V = 1; div_zero = 1. Otherwise div_zero = 0.
- FSM states:
  - IDLE: on start, single-cycle ops, divide-by-zero and reserved go to DONE; MUL/MULU/DIV/MOD go to CALC.
  - CALC: WIDTH iterations, one per cycle, then DONE.
  - DONE: registers result and flags, pulses done, returns to IDLE.

## Timing
- Reset (async assert, sync deassert) sets:
  - state IDLE; busy 0; done 0; result 0; flags_nzcv 0000; div_zero 0.
- Start accepted at edge k:
  - Single-cycle op: busy = 1 and done = 1 in cycle k+1.
  - Iterative op: busy = 1 in cycles k+1 … k+WIDTH+1; done = 1 only in cycle k+WIDTH+1.
- busy = 0 in the cycle after done. A start in that cycle is accepted, giving back-to-back single-cycle ops one result every 2 cycles.
- start while busy = 1 is dropped, with no queueing.
- Reset mid-CALC aborts the operation. Outputs return to reset values and no done is issued.
- result and flags change only on the done cycle.

## Structure
- Package alu_pkg holds:
  - alu_op_e, 4-bit enum of the codes above;
  - flag index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0;
  - alu_state_e {IDLE, CALC, DONE}.
- Sub-module alu_iter_muldiv, parameter WIDTH:
  - shift-add multiplier and restoring divider sharing one 2·WIDTH accumulator;
  - ports: load, mode, step, product, quotient, remainder.
- Top-level alu_seq holds the FSM, the single-cycle combinational ops and the output registers.

## Test plan
All scenarios use WIDTH = 16.
- ADD 0x7FFF + 0x0001, cin = 0 -> done at k+1; result 0x8000; NZCV = 1001.
- SUB 0x0000 − 0x0001, cin = 0 -> result 0xFFFF; NZCV = 1010. Then CMP 5, 5 -> result 0; NZCV = 0100.
- MUL 0x1234 × 0x0100 -> done only at k+17, busy high k+1 … k+17; result 0x3400; V = 1. MULU of the same operands -> 0x0012.
- DIV 100 / 7 -> 14 at k+17; MOD 100, 7 -> 2. DIV 5 / 0 -> done at k+1; result 0xFFFF; V = 1; div_zero = 1.
- ROR 0x0001 by 17 -> 0x8000; NZCV = 1000. ASR 0x8000 by 20 -> 0xFFFF. LSL 0x0001 by 16 -> 0x0000; Z = 1.
- Start DIV, pulse start with ADD at k+5, then assert rst_n = 0 at k+8 -> the ADD is ignored; no done is issued; all outputs return to reset values; a fresh ADD after reset completes normally.
